// File: rtl/pecell_seq_ctrl.sv
// Purpose : job sequencer for one PE cell. It runs accumulator clear, weight load,
//           data compute and pipeline drain, then pulses done.
// Latency : accept at T -> CLR at T+1; done at T+2+wlen+dlen+DRAIN_CYC (no stalls,
//           dlen!=0). The next command is accepted from the cycle after DONE.
// Backpr. : a low src_valid in LOAD/COMP stalls the job with no timeout. cmd_ready
//           is high only in IDLE, and cmd_* inputs are ignored while busy.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  job command handshake; cmd_wlen/cmd_dlen are the lengths
//   abort                synchronous job abort (ignored in IDLE and DONE)
//   src_valid/src_ready  operand source handshake (beat = src_valid & src_ready)
//   pe_acc_clr           clear PE accumulator (CLR state)
//   pe_w_load            PE latches src word as a weight (LOAD beat)
//   pe_d_en              PE consumes src word as data (COMP beat)
//   busy                 controller not idle
//   done / aborted       one-cycle completion / termination pulses

module pecell_seq_ctrl #(
  parameter int CNT_W     = 8,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_wlen,
  input  logic [CNT_W-1:0] cmd_dlen,
  input  logic             abort,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             pe_acc_clr,
  output logic             pe_w_load,
  output logic             pe_d_en,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_COMP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // The beat counter is reused to time DRAIN. It counts 0..DRAIN_CYC-1.
  localparam logic [CNT_W-1:0] DRAIN_LAST =
    (DRAIN_CYC > 0) ? CNT_W'(DRAIN_CYC - 1) : '0;

  // State after the final COMP beat. With no pipeline latency DRAIN is skipped.
  localparam logic [2:0] ST_AFTER_COMP = (DRAIN_CYC == 0) ? ST_DONE : ST_DRAIN;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wlen_q, wlen_d;
  logic [CNT_W-1:0] dlen_q, dlen_d;
  logic             aborted_q, aborted_d;

  logic             in_load;
  logic             in_comp;
  logic             beat;
  logic [CNT_W-1:0] cnt_inc;

  // ---------------------------------------------------------------------------
  // Output decode, from registered state only (plus the src_valid qualifier).
  // ---------------------------------------------------------------------------
  assign in_load    = (state_q == ST_LOAD);
  assign in_comp    = (state_q == ST_COMP);

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign pe_acc_clr = (state_q == ST_CLR);
  assign done       = (state_q == ST_DONE);
  assign aborted    = aborted_q;

  assign src_ready  = in_load | in_comp;
  assign beat       = src_valid & src_ready;

  // The strobes are qualified by state. LOAD and COMP are exclusive, so
  // w_load and d_en can never assert together.
  assign pe_w_load  = in_load & src_valid;
  assign pe_d_en    = in_comp & src_valid;

  // The count cannot wrap. The counter clears on the beat where cnt+1 equals
  // the length, so it never exceeds 2^CNT_W-2 before that increment.
  assign cnt_inc    = cnt_q + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wlen_d    = wlen_q;
    dlen_d    = dlen_q;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          wlen_d  = cmd_wlen;
          dlen_d  = cmd_dlen;
          cnt_d   = '0;
          state_d = ST_CLR;
        end
      end

      ST_CLR: begin
        if (wlen_q != '0) begin
          state_d = ST_LOAD;
        end else if (dlen_q != '0) begin
          state_d = ST_COMP;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_LOAD: begin
        if (beat) begin
          if (cnt_inc == wlen_q) begin
            cnt_d   = '0;
            state_d = (dlen_q != '0) ? ST_COMP : ST_DONE;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
      end

      ST_COMP: begin
        if (beat) begin
          if (cnt_inc == dlen_q) begin
            cnt_d   = '0;
            state_d = ST_AFTER_COMP;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
      end

      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_inc;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // An abort wins over any transition in an active state. DONE has already
    // finished the job, so it still completes normally.
    if (abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wlen_q    <= '0;
      dlen_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wlen_q    <= wlen_d;
      dlen_q    <= dlen_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_pecell_seq_ctrl.sv
// Directed bench for pecell_seq_ctrl (CNT_W=8, DRAIN_CYC=2).
// Inputs are driven 1 ns after the rising edge. A monitor samples outputs on
// the falling edge and keeps strobe counts and the cycle numbers of events.

module tb_pecell_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_wlen = '0;
  logic [7:0] cmd_dlen = '0;
  logic       abort = 1'b0;
  logic       src_valid = 1'b1;
  logic       src_ready;
  logic       pe_acc_clr, pe_w_load, pe_d_en, busy, done, aborted;

  pecell_seq_ctrl #(.CNT_W(8), .DRAIN_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wlen(cmd_wlen), .cmd_dlen(cmd_dlen),
    .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready),
    .pe_acc_clr(pe_acc_clr), .pe_w_load(pe_w_load), .pe_d_en(pe_d_en),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor counters
  int n_clr, n_wl, n_de, n_done, n_abt, n_acc, n_bad;
  int acc_cyc, done_cyc, abt_cyc, clr_cyc;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin n_acc++; acc_cyc = cyc; end
      if (pe_acc_clr) begin n_clr++; clr_cyc = cyc; end
      if (pe_w_load) n_wl++;
      if (pe_d_en)   n_de++;
      if (done)      begin n_done++; done_cyc = cyc; end
      if (aborted)   begin n_abt++;  abt_cyc  = cyc; end
      if ((pe_w_load && pe_d_en) || ((pe_w_load || pe_d_en) && !src_valid) ||
          (done && aborted))
        n_bad++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    n_clr = 0; n_wl = 0; n_de = 0; n_done = 0; n_abt = 0; n_acc = 0; n_bad = 0;
    acc_cyc = -1; done_cyc = -1; abt_cyc = -1; clr_cyc = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a command in the current (idle) cycle. Returns at the next drive point.
  task automatic start(input int wl, input int dl);
    cmd_valid = 1'b1;
    cmd_wlen  = 8'(wl);
    cmd_dlen  = 8'(dl);
    step();
    cmd_valid = 1'b0;
  endtask

  // Wait, bounded, for done or aborted, then step into the following idle cycle.
  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (n_done == 0 && n_abt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, int'(n_done != 0 || n_abt != 0), 1);
    step();
  endtask

  initial begin
    clr_counts();
    // Reset state while rst_n is low
    #3;
    check("rst_busy",      busy,      0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_strobes",   int'({pe_acc_clr, pe_w_load, pe_d_en, src_ready}), 0);
    check("rst_done_abt",  int'({done, aborted}), 0);
    step();
    rst_n = 1'b1;
    step();

    // Test 2: wlen=3, dlen=4, src_valid=1
    clr_counts();
    src_valid = 1'b1;
    start(3, 4);
    wait_end("t2", 40);
    check("t2_clr",     n_clr, 1);
    check("t2_wload",   n_wl,  3);
    check("t2_den",     n_de,  4);
    check("t2_done",    n_done, 1);
    check("t2_latency", done_cyc - acc_cyc, 11);
    check("t2_abt",     n_abt, 0);

    // Test 3: wlen=2, dlen=2, src_valid toggling 0,1,0,1... from the accept cycle
    clr_counts();
    cmd_valid = 1'b1; cmd_wlen = 8'd2; cmd_dlen = 8'd2;
    src_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      cmd_valid = 1'b0;
      src_valid = ~src_valid;
    end
    src_valid = 1'b1;
    wait_end("t3", 10);
    check("t3_wload",   n_wl, 2);
    check("t3_den",     n_de, 2);
    check("t3_latency", done_cyc - acc_cyc, 12);

    // Test 4: wlen=0, dlen=0, abort in the IDLE accept cycle and in DONE
    clr_counts();
    abort = 1'b1;
    start(0, 0);            // now in CLR
    abort = 1'b0;
    step();                 // now in DONE
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    check("t4_accept",  n_acc, 1);
    check("t4_clr_at",  clr_cyc - acc_cyc, 1);
    check("t4_done_at", done_cyc - acc_cyc, 2);
    check("t4_done",    n_done, 1);
    check("t4_abt",     n_abt, 0);
    check("t4_beats",   n_wl + n_de, 0);

    // Test 5: abort on 2nd COMP beat of dlen=5, then a new command in the abort pulse cycle
    clr_counts();
    begin
      int t0;
      start(0, 5);          // T+1 CLR
      t0 = acc_cyc;
      step();               // T+2 COMP beat 1
      step();               // T+3 COMP beat 2
      abort = 1'b1;
      step();               // T+4 IDLE, aborted pulse
      abort = 1'b0;
      check("t5_den", n_de, 2);
      start(1, 1);          // accepted at T+4
      check("t5_abt_at",  abt_cyc - t0, 4);
      check("t5_abt_cnt", n_abt, 1);
      check("t5_acc2_at", acc_cyc - t0, 4);
      n_abt = 0;
      wait_end("t5", 20);
      check("t5_done",     n_done, 1);
      check("t5_latency2", done_cyc - acc_cyc, 6);
      check("t5_wload",    n_wl, 1);
      check("t5_abt_once", n_abt, 0);
    end

    // Test 6: maximum lengths, then back-to-back commands
    clr_counts();
    start(255, 255);
    wait_end("t6", 600);
    check("t6_wload",   n_wl, 255);
    check("t6_den",     n_de, 255);
    check("t6_done",    n_done, 1);
    check("t6_latency", done_cyc - acc_cyc, 514);

    clr_counts();
    cmd_valid = 1'b1; cmd_wlen = 8'd1; cmd_dlen = 8'd0;
    repeat (12) step();
    cmd_valid = 1'b0;
    repeat (3) step();
    check("t6_b2b_acc",  n_acc, 3);
    check("t6_b2b_done", n_done, 3);
    check("t6_b2b_wl",   n_wl, 3);

    // Test 1: reset asserted mid-COMP
    clr_counts();
    start(0, 10);           // CLR
    step();                 // COMP
    step();                 // COMP
    rst_n = 1'b0;
    #1;
    check("t1_busy",      busy, 0);
    check("t1_cmd_ready", cmd_ready, 1);
    check("t1_strobes",   int'({pe_acc_clr, pe_w_load, pe_d_en, src_ready}), 0);
    check("t1_done_abt",  int'({done, aborted}), 0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("t1_no_done", n_done, 0);
    check("t1_idle",    busy, 0);

    check("protocol_violations", n_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
